// File: rtl/tri_bus_driver_pkg.sv
// Shared types for the tristate nibble-bus transmitter: FSM state encoding
// and the counter-width helper.
package tri_bus_driver_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_PAR   = 2'd2,
    S_TURN  = 2'd3
  } state_e;

  // Width needed to count 0..n-1, with one spare bit so a count never wraps.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/tri_drv_pad.sv
// Combinational tristate pad: each lane drives its data bit when enabled,
// otherwise releases to 'z. This is the only place the bus can go to 'z.
module tri_drv_pad #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] oe_i,
  input  logic [WIDTH-1:0] d_i,
  output tri   [WIDTH-1:0] bus_o
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    assign bus_o[g] = oe_i[g] ? d_i[g] : 1'bz;
  end

endmodule

// File: rtl/tri_bus_driver.sv
// Transmit end of the shared tristate bus: serialises a frame LSB beat first,
// then releases all lanes for a turnaround gap. Define TRI_BUS_DRIVER_PARITY_EN
// to append a per-lane even-parity beat after the data beats.
module tri_bus_driver
  import tri_bus_driver_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int BEATS    = 2,
  parameter int TURN_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*BEATS-1:0] in_data,
  input  logic [WIDTH-1:0]       in_mask,
  output tri   [WIDTH-1:0]       bus,
  output logic [WIDTH-1:0]       bus_oe,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int CW = cnt_w(BEATS);
  localparam int TW = cnt_w(TURN_CYC);
  localparam int FW = WIDTH * BEATS;

  state_e           state_q, state_d;
  logic [CW-1:0]    beat_q, beat_d;
  logic [TW-1:0]    turn_q, turn_d;
  logic [FW-1:0]    shreg_q, shreg_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] oe_q, oe_d;

`ifdef TRI_BUS_DRIVER_PARITY_EN
  logic [WIDTH-1:0] par_q, par_d, par_in;

  always_comb begin
    par_in = '0;
    for (int k = 0; k < BEATS; k++) par_in ^= in_data[k*WIDTH +: WIDTH];
  end
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    turn_d  = turn_q;
    shreg_d = shreg_q;
    mask_d  = mask_q;
    oe_d    = oe_q;
`ifdef TRI_BUS_DRIVER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DRIVE;
          shreg_d = in_data;
          mask_d  = in_mask;
          oe_d    = in_mask;
          beat_d  = '0;
`ifdef TRI_BUS_DRIVER_PARITY_EN
          par_d   = par_in;
`endif
        end
      end
      S_DRIVE: begin
        if (beat_q == CW'(BEATS - 1)) begin
`ifdef TRI_BUS_DRIVER_PARITY_EN
          state_d = S_PAR;
          shreg_d = FW'(par_q);
          oe_d    = mask_q;
`else
          state_d = S_TURN;
          oe_d    = '0;
          turn_d  = '0;
`endif
        end else begin
          beat_d  = beat_q + CW'(1);
          shreg_d = shreg_q >> WIDTH;
          oe_d    = mask_q;
        end
      end
      S_PAR: begin
        state_d = S_TURN;
        oe_d    = '0;
        turn_d  = '0;
      end
      S_TURN: begin
        if (turn_q == TW'(TURN_CYC - 1)) state_d = S_IDLE;
        else turn_d = turn_q + TW'(1);
      end
      default: begin
        state_d = S_IDLE;
        oe_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      turn_q  <= '0;
      shreg_q <= '0;
      mask_q  <= '0;
      oe_q    <= '0;
`ifdef TRI_BUS_DRIVER_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      turn_q  <= turn_d;
      shreg_q <= shreg_d;
      mask_q  <= mask_d;
      oe_q    <= oe_d;
`ifdef TRI_BUS_DRIVER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_TURN) && (turn_q == TW'(TURN_CYC - 1));
  assign bus_oe     = oe_q;

  tri_drv_pad #(.WIDTH(WIDTH)) u_pad (
    .oe_i  (oe_q),
    .d_i   (shreg_q[WIDTH-1:0]),
    .bus_o (bus)
  );

endmodule

// File: tb/tb_tri_bus_driver.sv
// Randomized scoreboard bench for tri_bus_driver: each accepted frame expands
// into a queue of expected bus cycles that a negedge monitor pops and checks.
module tb_tri_bus_driver;

  localparam int W = 4;
  localparam int B = 2;
  localparam int T = 1;
`ifdef TRI_BUS_DRIVER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct packed {
    logic [W-1:0] oe;
    logic [W-1:0] val;
    logic         done;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W*B-1:0] in_data = '0;
  logic [W-1:0] in_mask = '0;
  wire  [W-1:0] bus;
  logic [W-1:0] bus_oe;
  logic         busy;
  logic         frame_done;
  logic [W-1:0] bus_isz;

  rec_t q[$];
  int   remain = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  tri_bus_driver #(.WIDTH(W), .BEATS(B), .TURN_CYC(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mask    (in_mask),
    .bus        (bus),
    .bus_oe     (bus_oe),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Receiver-style released-lane test, one lane at a time.
  for (genvar g = 0; g < W; g++) begin : g_z
    assign bus_isz[g] = (bus[g] === 1'bz);
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected cycles of one frame: data beats, optional parity beat, turnaround.
  task automatic push_frame(input logic [W*B-1:0] d, input logic [W-1:0] m);
    logic [W-1:0] p;
    logic [W-1:0] beat;
    p = '0;
    for (int b = 0; b < B; b++) begin
      beat = d[b*W +: W];
      p = p ^ beat;
      q.push_back('{oe: m, val: beat & m, done: 1'b0});
    end
    if (PAR != 0) q.push_back('{oe: m, val: p & m, done: 1'b0});
    for (int t = 0; t < T; t++) q.push_back('{oe: '0, val: '0, done: (t == T - 1)});
  endtask

  task automatic cycle(input logic v, input logic [W*B-1:0] d, input logic [W-1:0] m, input logic r);
    @(negedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    in_mask  = m;
    rst_n    = r;
    @(posedge clk);
    if (!r) begin
      q.delete();
      remain = 0;
    end else if (remain > 0) begin
      remain--;
    end else if (v) begin
      push_frame(d, m);
      remain = B + PAR + T;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'($urandom), 4'($urandom), 1'b1);
  endtask

  always @(negedge clk) begin
    rec_t r;
    logic exp_busy;
    if (mon_en) begin
      if (q.size() > 0) begin
        r = q.pop_front();
        exp_busy = 1'b1;
      end else begin
        r = '{oe: '0, val: '0, done: 1'b0};
        exp_busy = 1'b0;
      end
      chk("bus_oe", bus_oe, r.oe);
      chk("bus_z_lanes", bus_isz, ~r.oe);
      chk("bus_data", bus & r.oe, r.val);
      chk("frame_done", W'(frame_done), W'(r.done));
      chk("busy", W'(busy), W'(exp_busy));
      chk("in_ready", W'(in_ready), W'(!exp_busy));
    end
  end

  initial begin
    cycle(1'b0, '0, '0, 1'b0);
    cycle(1'b1, 8'hA5, 4'hF, 1'b0);
    mon_en = 1'b1;

    cycle(1'b1, 8'hA5, 4'hF, 1'b1);
    idle(4);
    cycle(1'b1, 8'hFF, 4'b1101, 1'b1);
    cycle(1'b1, 8'h00, 4'hF, 1'b1);
    idle(4);
    cycle(1'b1, 8'h5A, 4'h0, 1'b1);
    idle(4);
    cycle(1'b1, 8'hA5, 4'hF, 1'b1);
    cycle(1'b1, 8'h3C, 4'hF, 1'b0);
    cycle(1'b1, 8'h5A, 4'hF, 1'b1);
    idle(5);
    cycle(1'b1, 8'h3C, 4'hF, 1'b1);
    idle(5);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom),
            $urandom_range(0, 40) != 0);
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
